// File: rtl/sc_regbank_fixedmix.sv
// Register bank with read-only constant registers at the bottom of the map,
// writable registers above them supporting load/increment/decrement, two
// combinational read ports, and a sequenced clear sweep of the writable part.
module sc_regbank_fixedmix #(
    parameter int                         DATAWIDTH_BUS      = 32,
    parameter int                         ADDRWIDTH          = 4,
    parameter int                         REG_COUNT          = 16,
    parameter int                         FIXED_COUNT        = 4,
    parameter logic [DATAWIDTH_BUS-1:0]   DATA_REGFIXED_INIT = '0,
    parameter logic [DATAWIDTH_BUS-1:0]   DATA_REG_INIT      = '0,
    parameter bit                         BYPASS             = 1'b1
) (
    input  logic                      SC_RegBANK_CLOCK_50,
    input  logic                      SC_RegBANK_RESET_InHigh,
    input  logic [1:0]                SC_RegBANK_op_InBUS,
    input  logic [ADDRWIDTH-1:0]      SC_RegBANK_wAddr_InBUS,
    input  logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_data_InBUS,
    input  logic                      SC_RegBANK_clear_InLow,
    input  logic [ADDRWIDTH-1:0]      SC_RegBANK_rAddrA_InBUS,
    input  logic [ADDRWIDTH-1:0]      SC_RegBANK_rAddrB_InBUS,
    output logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataA_OutBUS,
    output logic [DATAWIDTH_BUS-1:0]  SC_RegBANK_dataB_OutBUS,
    output logic                      SC_RegBANK_busy_Out,
    output logic                      SC_RegBANK_err_Out
);

    // Storage spans the full address space so every address indexes it
    // directly; only the writable window is ever written, the rest stays
    // constant and is masked on reads.
    localparam int                        DEPTH    = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH:0]        REG_CNT  = (ADDRWIDTH + 1)'(REG_COUNT);
    localparam logic [ADDRWIDTH:0]        FIX_CNT  = (ADDRWIDTH + 1)'(FIXED_COUNT);
    localparam logic [ADDRWIDTH:0]        LAST_PTR = (ADDRWIDTH + 1)'(REG_COUNT - 1);
    localparam logic [ADDRWIDTH:0]        PTR_ONE  = (ADDRWIDTH + 1)'(1);
    localparam logic [DATAWIDTH_BUS-1:0]  ONE      = DATAWIDTH_BUS'(1);

    typedef enum logic [0:0] {ST_IDLE, ST_SWEEP} state_t;

    state_t                      state_q;
    logic [ADDRWIDTH:0]          ptr_q;
    logic                        err_q;
    logic [DATAWIDTH_BUS-1:0]    mem_q [DEPTH];

    logic [ADDRWIDTH:0]          waddr_x;
    logic                        busy;
    logic                        clear_req;
    logic                        addr_ok;
    logic                        op_active;
    logic                        reject;
    logic                        op_ok;
    logic                        load_ok;

    logic                        wr_en_d;
    logic [ADDRWIDTH-1:0]        wr_idx_d;
    logic [DATAWIDTH_BUS-1:0]    wr_data_d;

    assign waddr_x   = {1'b0, SC_RegBANK_wAddr_InBUS};
    assign busy      = (state_q == ST_SWEEP);
    // A clear request sampled in IDLE owns the cycle, so ops are refused then too.
    assign clear_req = (state_q == ST_IDLE) && !SC_RegBANK_clear_InLow;
    assign addr_ok   = (waddr_x >= FIX_CNT) && (waddr_x < REG_CNT);
    assign op_active = (SC_RegBANK_op_InBUS != 2'b00);
    assign reject    = op_active && (!addr_ok || busy || clear_req);
    assign op_ok     = op_active && !reject;
    // Bypass only for loads that will actually be committed at the next edge.
    assign load_ok   = op_ok && (SC_RegBANK_op_InBUS == 2'b01);

    // Read mux: out-of-range -> 0, fixed region -> constant, else bypass or stored.
    function automatic logic [DATAWIDTH_BUS-1:0] read_mux(
        input logic [ADDRWIDTH-1:0]     a,
        input logic [DATAWIDTH_BUS-1:0] stored,
        input logic                     byp_en,
        input logic [ADDRWIDTH-1:0]     byp_addr,
        input logic [DATAWIDTH_BUS-1:0] byp_data
    );
        logic [ADDRWIDTH:0] ax;
        ax = {1'b0, a};
        if (ax >= REG_CNT)
            return '0;
        else if (ax < FIX_CNT)
            return DATA_REGFIXED_INIT + DATAWIDTH_BUS'(a);
        else if (BYPASS && byp_en && (a == byp_addr))
            return byp_data;
        else
            return stored;
    endfunction

    assign SC_RegBANK_dataA_OutBUS = read_mux(SC_RegBANK_rAddrA_InBUS,
                                              mem_q[SC_RegBANK_rAddrA_InBUS],
                                              load_ok, SC_RegBANK_wAddr_InBUS,
                                              SC_RegBANK_data_InBUS);
    assign SC_RegBANK_dataB_OutBUS = read_mux(SC_RegBANK_rAddrB_InBUS,
                                              mem_q[SC_RegBANK_rAddrB_InBUS],
                                              load_ok, SC_RegBANK_wAddr_InBUS,
                                              SC_RegBANK_data_InBUS);
    assign SC_RegBANK_busy_Out     = busy;
    assign SC_RegBANK_err_Out      = err_q;

    // Single write port: the sweep has priority (ops are rejected while busy anyway).
    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = '0;
        wr_data_d = DATA_REG_INIT;
        if (busy) begin
            if (ptr_q < REG_CNT) begin
                wr_en_d  = 1'b1;
                wr_idx_d = ptr_q[ADDRWIDTH-1:0];
            end
        end else if (op_ok) begin
            wr_en_d  = 1'b1;
            wr_idx_d = SC_RegBANK_wAddr_InBUS;
            case (SC_RegBANK_op_InBUS)
                2'b01:   wr_data_d = SC_RegBANK_data_InBUS;
                2'b10:   wr_data_d = mem_q[SC_RegBANK_wAddr_InBUS] + ONE;
                2'b11:   wr_data_d = mem_q[SC_RegBANK_wAddr_InBUS] - ONE;
                default: wr_data_d = mem_q[SC_RegBANK_wAddr_InBUS];
            endcase
        end
    end

    // Register storage, clear-sweep FSM and registered error pulse.
    always_ff @(posedge SC_RegBANK_CLOCK_50 or posedge SC_RegBANK_RESET_InHigh) begin
        if (SC_RegBANK_RESET_InHigh) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= DATA_REG_INIT;
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= reject;
            if (wr_en_d)
                mem_q[wr_idx_d] <= wr_data_d;
            case (state_q)
                ST_IDLE: begin
                    if (!SC_RegBANK_clear_InLow) begin
                        state_q <= ST_SWEEP;
                        ptr_q   <= FIX_CNT;
                    end
                end
                ST_SWEEP: begin
                    // With no writable registers ptr starts past the end: one busy cycle.
                    if (ptr_q >= LAST_PTR) begin
                        state_q <= ST_IDLE;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + PTR_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_regbank_fixedmix.sv
// Testbench for sc_regbank_fixedmix: directed steps followed by random
// traffic, all checked against a behavioural register-bank model.
module tb_sc_regbank_fixedmix;

    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          RC    = 16;
    localparam int          FC    = 4;
    localparam logic [31:0] FINIT = 32'h10;
    localparam logic [31:0] RINIT = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    op;
    logic [AW-1:0] wa, ra, rb;
    logic [DW-1:0] din;
    logic          clr;
    logic [DW-1:0] da, db;
    logic          busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [31:0] m [RC];
    bit          m_busy;
    int          sw_left;
    bit          exp_err;
    logic [31:0] last_a;
    int          n;

    sc_regbank_fixedmix #(
        .DATAWIDTH_BUS(DW), .ADDRWIDTH(AW), .REG_COUNT(RC), .FIXED_COUNT(FC),
        .DATA_REGFIXED_INIT(FINIT), .DATA_REG_INIT(RINIT), .BYPASS(1'b1)
    ) dut (
        .SC_RegBANK_CLOCK_50    (clk),
        .SC_RegBANK_RESET_InHigh(rst),
        .SC_RegBANK_op_InBUS    (op),
        .SC_RegBANK_wAddr_InBUS (wa),
        .SC_RegBANK_data_InBUS  (din),
        .SC_RegBANK_clear_InLow (clr),
        .SC_RegBANK_rAddrA_InBUS(ra),
        .SC_RegBANK_rAddrB_InBUS(rb),
        .SC_RegBANK_dataA_OutBUS(da),
        .SC_RegBANK_dataB_OutBUS(db),
        .SC_RegBANK_busy_Out    (busy),
        .SC_RegBANK_err_Out     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = FC; i < RC; i++) m[i] = RINIT;
        m_busy  = 1'b0;
        sw_left = 0;
        exp_err = 1'b0;
    endtask

    // What a read port should show right now, given the current inputs.
    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int ai, wi;
        bit load_acc;
        ai = int'(a);
        wi = int'(wa);
        load_acc = (op == 2'b01) && (wi >= FC) && (wi < RC) && !m_busy && clr;
        if (ai >= RC) return 32'h0;
        if (ai < FC) return FINIT + 32'(ai);
        if (load_acc && ai == wi) return din;
        return m[ai];
    endfunction

    // Effect of one rising edge on the model.
    task automatic model_edge();
        int wi;
        wi = int'(wa);
        exp_err = (op != 2'b00) && (wi < FC || wi >= RC || m_busy || !clr);
        if (m_busy) begin
            m[RC - sw_left] = RINIT;
            sw_left--;
            if (sw_left == 0) m_busy = 1'b0;
        end else if (!clr) begin
            m_busy  = 1'b1;
            sw_left = RC - FC;
        end else if (!exp_err) begin
            case (op)
                2'b01:   m[wi] = din;
                2'b10:   m[wi] = m[wi] + 32'd1;
                2'b11:   m[wi] = m[wi] - 32'd1;
                default: ;
            endcase
        end
    endtask

    // One clock: check reads before the edge, err/busy after it.
    task automatic cycle();
        #1;
        last_a = da;
        chk("rdA", da, model_read(ra));
        chk("rdB", db, model_read(rb));
        @(posedge clk);
        model_edge();
        #1;
        chk("err", 32'(err), 32'(exp_err));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    initial begin
        rst = 1'b1; op = 2'b00; wa = '0; ra = '0; rb = '0; din = '0; clr = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // reset contents
        for (int i = 0; i < RC; i++) begin
            ra = 5'(i); rb = 5'(RC - 1 - i);
            cycle();
            chk("rst_reg", last_a, (i < FC) ? FINIT + 32'(i) : RINIT);
        end
        ra = 5'd20; cycle();
        chk("oob_read", last_a, 32'h0);

        // load with same-cycle bypass
        op = 2'b01; wa = 5'd5; din = 32'hDEADBEEF; ra = 5'd5; rb = 5'd5;
        cycle();
        chk("bypass", last_a, 32'hDEADBEEF);
        op = 2'b00; cycle();
        chk("r5_stored", last_a, 32'hDEADBEEF);

        // increment wrap
        op = 2'b01; wa = 5'd6; din = 32'hFFFFFFFF; ra = 5'd6; cycle();
        op = 2'b10; cycle();
        chk("inc_no_bypass", last_a, 32'hFFFFFFFF);
        op = 2'b00; cycle();
        chk("inc_wrap", last_a, 32'h0);

        // decrement wrap, twice
        op = 2'b11; cycle();
        op = 2'b11; cycle();
        chk("dec_wrap", last_a, 32'hFFFFFFFF);
        op = 2'b00; cycle();
        chk("dec_twice", last_a, 32'hFFFFFFFE);

        // write to fixed register
        op = 2'b01; wa = 5'd2; din = 32'h55; ra = 5'd2; cycle();
        chk("fixed_err", 32'(err), 32'h1);
        chk("fixed_no_byp", last_a, 32'h12);
        op = 2'b00; cycle();
        chk("fixed_err_end", 32'(err), 32'h0);
        chk("r2_kept", last_a, 32'h12);

        // write beyond REG_COUNT
        op = 2'b01; wa = 5'd20; din = 32'h77; ra = 5'd20; cycle();
        chk("oob_err", 32'(err), 32'h1);
        op = 2'b00; cycle();
        chk("oob_err_end", 32'(err), 32'h0);

        // clear sweep, with a load attempt in the middle
        ra = 5'd5; clr = 1'b0; cycle();
        clr = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            op = (n == 3) ? 2'b01 : 2'b00; wa = 5'd7; din = 32'h1234; ra = 5'd7;
            cycle();
            if (n == 3) chk("sweep_load_err", 32'(err), 32'h1);
            n++;
        end
        op = 2'b00;
        chk("sweep_len", 32'(n), 32'd12);
        ra = 5'd5; cycle(); chk("clr_r5", last_a, 32'h0);
        ra = 5'd6; cycle(); chk("clr_r6", last_a, 32'h0);
        ra = 5'd7; cycle(); chk("clr_r7", last_a, 32'h0);
        ra = 5'd3; cycle(); chk("clr_r3", last_a, 32'h13);

        // reset during the 5th sweep cycle
        op = 2'b01; wa = 5'd9; din = 32'hAAAA; ra = 5'd9; cycle();
        op = 2'b01; wa = 5'd15; din = 32'hBBBB; cycle();
        op = 2'b00; clr = 1'b0; cycle();
        clr = 1'b1;
        repeat (4) cycle();
        chk("mid_busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_busy", 32'(busy), 32'h0);
        ra = 5'd9; rb = 5'd15; #1;
        chk("mid_rst_r9", da, 32'h0);
        chk("mid_rst_r15", db, 32'h0);
        #1;
        rst = 1'b0;
        cycle();

        // random traffic
        repeat (400) begin
            op  = 2'($urandom_range(0, 3));
            wa  = 5'($urandom_range(0, 19));
            case ($urandom_range(0, 3))
                0:       din = 32'hFFFFFFFF;
                1:       din = 32'h0;
                default: din = $urandom;
            endcase
            clr = ($urandom_range(0, 24) != 0);
            ra  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 19));
            rb  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 19));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
